// File: rtl/alu_issue_stage_pkg.sv
// Shared ISA constants for the ALU issue stage: ALU control codes, RV32I major
// opcodes, datapath width and the funct3 -> ALU control helper.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
// The optional strict funct7 check in the decoder is enabled by ALU_ISSUE_ILLEGAL_EN.
package alu_issue_stage_pkg;

  localparam int XLEN = 32;

  // ALUControl codes driven onto the EX stage ALU.
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 -> ALU control for OP/OP-IMM; alt selects SUB/SRA.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] c;
    case (f3)
      3'b000:  c = alt ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode to ALU operands/control, rd, write enable, illegal.
// Latency: 0 cycles (pure combinational). Backpressure: none, stateless.
// Ports: instr_i/pc_i/rs1_i/rs2_i in; alu_a_o/alu_b_o/alu_ctrl_o/rd_o/reg_write_o/illegal_o out.
// ALU_ISSUE_ILLEGAL_EN: full funct7 / shift-imm check drives illegal_o; otherwise illegal_o=0.
module alu_issue_decode
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int LINK_INC = 4
) (
  input  logic [31:0]       instr_i,
  input  logic [XLEN_P-1:0] pc_i,
  input  logic [XLEN_P-1:0] rs1_i,
  input  logic [XLEN_P-1:0] rs2_i,
  output logic [XLEN_P-1:0] alu_a_o,
  output logic [XLEN_P-1:0] alu_b_o,
  output logic [3:0]        alu_ctrl_o,
  output logic [4:0]        rd_o,
  output logic              reg_write_o,
  output logic              illegal_o
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [XLEN_P-1:0] imm_i, imm_s, imm_u;
  logic              we;
  logic              bad;
  logic              f7_std;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign rd_o   = instr_i[11:7];

  assign imm_i  = XLEN_P'($signed(instr_i[31:20]));
  assign imm_s  = XLEN_P'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_u  = XLEN_P'($signed({instr_i[31:12], 12'b0}));
  assign f7_std = (f7 == 7'b0000000) || (f7 == 7'b0100000);

  always_comb begin
    alu_a_o    = rs1_i;
    alu_b_o    = rs2_i;
    alu_ctrl_o = ALU_ADD;
    we         = 1'b0;
    bad        = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_ctrl_o = alu_op(f3, f7[5]);
        we         = 1'b1;
        // The alternate encoding only exists for SUB and SRA.
        bad        = !f7_std || (f7[5] && (f3 != 3'b000) && (f3 != 3'b101));
      end
      OPC_OP_IMM: begin
        alu_b_o    = imm_i;
        // ADDI has no SUB form; imm[10] only means SRA for f3=101.
        alu_ctrl_o = alu_op(f3, (f3 == 3'b101) && instr_i[30]);
        we         = 1'b1;
        bad        = ((f3 == 3'b001) || (f3 == 3'b101)) && !f7_std;
      end
      OPC_LOAD: begin
        alu_b_o = imm_i;
        we      = 1'b1;
      end
      OPC_STORE: alu_b_o = imm_s;
      OPC_BRANCH: begin
        case (f3[2:1])
          2'b00:   alu_ctrl_o = ALU_SUB;
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: bad        = 1'b1;
        endcase
      end
      OPC_LUI: begin
        alu_ctrl_o = ALU_PASS_B;
        alu_b_o    = imm_u;
        we         = 1'b1;
      end
      OPC_AUIPC: begin
        alu_a_o = pc_i;
        alu_b_o = imm_u;
        we      = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        alu_a_o = pc_i;
        alu_b_o = XLEN_P'(LINK_INC);
        we      = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  assign illegal_o = bad;
`else
  // Strict checking disabled: encoding faults are ignored.
  assign illegal_o = bad & 1'b0;
`endif

  // x0 is never written, nor is anything when the encoding is rejected.
  assign reg_write_o = we && (rd_o != 5'd0) && !illegal_o;

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ID->EX issue stage feeding the ALU operand/control interface.
// Latency: 1 cycle, 1 instr/cycle. Backpressure: holds payload while out_valid & !out_ready; in_ready=!out_valid|out_ready.
// Ports: clk/rst_n/flush; in_valid/in_ready/instr/pc/rs1_data/rs2_data; out_valid/out_ready/alu_a/alu_b/alu_ctrl/rd/reg_write/illegal.
// ALU_ISSUE_ILLEGAL_EN enables strict funct7 checking in alu_issue_decode.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int LINK_INC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN_P-1:0] pc,
  input  logic [XLEN_P-1:0] rs1_data,
  input  logic [XLEN_P-1:0] rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN_P-1:0] alu_a,
  output logic [XLEN_P-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  output logic [4:0]        rd,
  output logic              reg_write,
  output logic              illegal
);

  logic [XLEN_P-1:0] dec_a, dec_b;
  logic [3:0]        dec_ctrl;
  logic [4:0]        dec_rd;
  logic              dec_we, dec_ill;

  logic              out_valid_d, out_valid_q;
  logic [XLEN_P-1:0] alu_a_q, alu_b_q;
  logic [3:0]        alu_ctrl_q;
  logic [4:0]        rd_q;
  logic              reg_write_q, illegal_q;
  logic              accept, load;

  alu_issue_decode #(
    .XLEN_P  (XLEN_P),
    .LINK_INC(LINK_INC)
  ) u_decode (
    .instr_i    (instr),
    .pc_i       (pc),
    .rs1_i      (rs1_data),
    .rs2_i      (rs2_data),
    .alu_a_o    (dec_a),
    .alu_b_o    (dec_b),
    .alu_ctrl_o (dec_ctrl),
    .rd_o       (dec_rd),
    .reg_write_o(dec_we),
    .illegal_o  (dec_ill)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // A flushed accept is consumed upstream but never reaches EX.
  assign load     = accept && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= ALU_ADD;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        alu_a_q     <= dec_a;
        alu_b_q     <= dec_b;
        alu_ctrl_q  <= dec_ctrl;
        rd_q        <= dec_rd;
        reg_write_q <= dec_we;
        illegal_q   <= dec_ill;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rd        = rd_q;
  assign reg_write = reg_write_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios then randomized traffic, all
// checked against a transaction-level model built from instruction mnemonics.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        we, ill;
    bit          ca, cb, cc, cr;
  } exp_t;

  localparam logic [2:0] RF3  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  localparam bit         RALT [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
  localparam logic [3:0] RCTL [10] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                                       ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
  localparam logic [3:0] F3CTL [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                       ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [2:0] AF3  [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  localparam logic [3:0] ACTL [6] = '{ALU_ADD, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND};
  localparam logic [2:0] BF3  [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [3:0] BCTL [6] = '{ALU_SUB, ALU_SUB, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd;
  logic        reg_write, illegal;

  int   total = 0;
  int   bad   = 0;
  bit   m_v;
  exp_t m_p, in_exp;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .rd(rd), .reg_write(reg_write), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                              input logic [4:0] r, input logic we, input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.ctrl = c; e.rd = r; e.we = we; e.ill = ill;
    e.ca = 1; e.cb = 1; e.cc = 1; e.cr = 1;
    return e;
  endfunction

  // Build a random instruction of the given class together with its expected issue payload.
  function automatic void gen(input int kind, input logic [31:0] pcv, input logic [31:0] r1,
                              input logic [31:0] r2, output logic [31:0] ins, output exp_t e);
    logic [4:0]  rdf, s1, s2;
    logic [11:0] imm;
    logic [19:0] u;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    int          k;
    rdf = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
    imm = 12'($urandom); u = 20'($urandom);
    e = mk(r1, r2, ALU_ADD, rdf, rdf != 0, 1'b0);
    case (kind)
      0: begin
        k = $urandom_range(9);
        ins = {RALT[k] ? 7'h20 : 7'h00, s2, s1, RF3[k], rdf, 7'h33};
        e.ctrl = RCTL[k];
      end
      1: begin
        k = $urandom_range(5);
        ins = {imm, s1, AF3[k], rdf, 7'h13};
        e.ctrl = ACTL[k]; e.b = sx12(imm);
      end
      2: begin
        k = $urandom_range(2);
        f3 = (k == 0) ? 3'b001 : 3'b101;
        imm = {(k == 2) ? 7'h20 : 7'h00, imm[4:0]};
        ins = {imm, s1, f3, rdf, 7'h13};
        e.ctrl = (k == 0) ? ALU_SLL : (k == 1) ? ALU_SRL : ALU_SRA;
        e.b = sx12(imm);
      end
      3: begin
        ins = {imm, s1, 3'b010, rdf, 7'h03};
        e.b = sx12(imm);
      end
      4: begin
        ins = {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'h23};
        e.b = sx12(imm); e.we = 0; e.cr = 0;
      end
      5: begin
        k = $urandom_range(5);
        ins = {imm[11:5], s2, s1, BF3[k], imm[4:0], 7'h63};
        e.ctrl = BCTL[k]; e.we = 0; e.cr = 0;
      end
      6: begin
        ins = {u, rdf, 7'h37};
        e.ctrl = ALU_PASS_B; e.b = {u, 12'h000}; e.ca = 0;
      end
      7: begin
        ins = {u, rdf, 7'h17};
        e.a = pcv; e.b = {u, 12'h000};
      end
      8: begin
        ins = {u, rdf, 7'h6F};
        e.a = pcv; e.b = 32'd4;
      end
      9: begin
        ins = {imm, s1, 3'b000, rdf, 7'h67};
        e.a = pcv; e.b = 32'd4;
      end
      10: begin
        do op = 7'($urandom);
        while (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 ||
               op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67);
        ins = {25'($urandom), op};
        e.ill = ILL_EN; e.we = 0; e.ca = 0; e.cb = 0; e.cr = 0;
      end
      default: begin
        // OP with a nonstandard funct7 (bit 5 clear, nonzero)
        f7 = 7'($urandom_range(1, 31));
        f3 = 3'($urandom);
        ins = {f7, s2, s1, f3, rdf, 7'h33};
        e.ctrl = F3CTL[f3];
        if (ILL_EN) begin
          e.ill = 1; e.we = 0; e.cc = 0;
        end
      end
    endcase
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] r1, input logic [31:0] r2, input logic ordy,
                       input logic fl, input exp_t e);
    in_valid = iv; instr = ins; pc = pcv; rs1_data = r1; rs2_data = r2;
    out_ready = ordy; flush = fl; in_exp = e;
  endtask

  // One clock of the stage: check in_ready, advance the model, check outputs.
  task automatic cycle(input string tag);
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_v || out_ready));
    @(posedge clk);
    if (flush) m_v = 0;
    else if (in_valid && (!m_v || out_ready)) begin
      m_v = 1; m_p = in_exp;
    end else if (out_ready) m_v = 0;
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_v));
    if (m_v) begin
      if (m_p.ca) chk({tag, ".alu_a"}, alu_a, m_p.a);
      if (m_p.cb) chk({tag, ".alu_b"}, alu_b, m_p.b);
      if (m_p.cc) chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(m_p.ctrl));
      if (m_p.cr) chk({tag, ".rd"}, 32'(rd), 32'(m_p.rd));
      chk({tag, ".reg_write"}, 32'(reg_write), 32'(m_p.we));
      chk({tag, ".illegal"}, 32'(illegal), 32'(m_p.ill));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".alu_a"}, alu_a, 32'd0);
    chk({tag, ".alu_b"}, alu_b, 32'd0);
    chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(ALU_ADD));
    chk({tag, ".rd"}, 32'(rd), 32'd0);
    chk({tag, ".reg_write"}, 32'(reg_write), 32'd0);
    chk({tag, ".illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    logic [31:0] ins, pcv, r1, r2;
    exp_t        e, dc;
    dc = mk(0, 0, ALU_ADD, 0, 0, 0);
    m_v = 0; m_p = dc;

    // Reset state
    rst_n = 1'b0;
    drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, dc);
    #1;
    chk_reset("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD x3,x1,x2
    drive(1, {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 32'h0, 32'd5, 32'd7, 1, 0,
          mk(32'd5, 32'd7, ALU_ADD, 5'd3, 1, 0));
    cycle("add");
    // SRAI x4,x1,3
    drive(1, {12'h403, 5'd1, 3'b101, 5'd4, 7'h13}, 32'h0, 32'h8000_0000, 32'd1, 1, 0,
          mk(32'h8000_0000, 32'h403, ALU_SRA, 5'd4, 1, 0));
    cycle("srai");
    // SUB x4,x1,x2
    drive(1, {7'h20, 5'd2, 5'd1, 3'b000, 5'd4, 7'h33}, 32'h0, 32'd9, 32'd3, 1, 0,
          mk(32'd9, 32'd3, ALU_SUB, 5'd4, 1, 0));
    cycle("sub");

    // Backpressure: hold for 3 cycles, then release
    drive(1, {7'h00, 5'd2, 5'd1, 3'b110, 5'd8, 7'h33}, 32'h0, 32'h0F0F, 32'h00FF, 0, 0,
          mk(32'h0F0F, 32'h00FF, ALU_OR, 5'd8, 1, 0));
    repeat (3) cycle("bp_hold");
    out_ready = 1;
    cycle("bp_release");
    drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, dc);
    cycle("bp_drain");

    // Flush with accept, then LUI x5,0x12345
    drive(1, {7'h00, 5'd2, 5'd1, 3'b100, 5'd9, 7'h33}, 32'h0, 32'd1, 32'd2, 1, 1,
          mk(32'd1, 32'd2, ALU_XOR, 5'd9, 1, 0));
    cycle("flush");
    e = mk(32'h0, 32'h1234_5000, ALU_PASS_B, 5'd5, 1, 0); e.ca = 0;
    drive(1, {20'h12345, 5'd5, 7'h37}, 32'h0, 32'hDEAD, 32'h0, 1, 0, e);
    cycle("lui");

    // AUIPC pc=0x100 imm=1; JAL x0
    drive(1, {20'h00001, 5'd6, 7'h17}, 32'h100, 32'h55, 32'h66, 1, 0,
          mk(32'h100, 32'h1000, ALU_ADD, 5'd6, 1, 0));
    cycle("auipc");
    drive(1, {20'hABCDE, 5'd0, 7'h6F}, 32'h200, 32'h55, 32'h66, 1, 0,
          mk(32'h200, 32'd4, ALU_ADD, 5'd0, 0, 0));
    cycle("jal_x0");

    // Unknown opcode 0x7F; OP with funct7=0000001
    e = mk(0, 0, ALU_ADD, 0, 0, ILL_EN); e.ca = 0; e.cb = 0; e.cr = 0;
    drive(1, {25'h0, 7'h7F}, 32'h0, 32'h1, 32'h2, 1, 0, e);
    cycle("opc7f");
    e = ILL_EN ? mk(32'd10, 32'd20, ALU_ADD, 5'd7, 0, 1) : mk(32'd10, 32'd20, ALU_ADD, 5'd7, 1, 0);
    if (ILL_EN) e.cc = 0;
    drive(1, {7'h01, 5'd2, 5'd1, 3'b000, 5'd7, 7'h33}, 32'h0, 32'd10, 32'd20, 1, 0, e);
    cycle("op_f7_01");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      pcv = $urandom & 32'hFFFF_FFFC; r1 = $urandom; r2 = $urandom;
      gen($urandom_range(11), pcv, r1, r2, ins, e);
      drive(($urandom % 4) != 0, ins, pcv, r1, r2, ($urandom % 3) != 0, ($urandom % 16) == 0, e);
      cycle("rand");
    end

    // Reset while a payload is on the output
    drive(1, {7'h00, 5'd2, 5'd1, 3'b111, 5'd12, 7'h33}, 32'h0, 32'hF0, 32'h3C, 0, 0,
          mk(32'hF0, 32'h3C, ALU_AND, 5'd12, 1, 0));
    cycle("pre_rst");
    chk("pre_rst.held_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, dc);
    m_v = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
